// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding and
// the width of the big-endian word-count header.
package mips_pkg;

    localparam int HDR_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        CHECK  = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed byte image into instruction
// memory one 32-bit word at a time, and holds the processor in reset until
// the whole image has arrived with a matching checksum.
module imem_loader
    import mips_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    localparam logic [31:0] MAX_LIMIT = 32'(MAX_WORDS);

    loader_state_t          state;
    loader_state_t          next_state;
    logic [HDR_WIDTH-1:0]   word_count;
    logic [HDR_WIDTH-1:0]   word_index;
    logic [HDR_WIDTH-1:0]   rx_count;
    logic [1:0]             byte_pos;
    logic [23:0]            assembly;
    logic [7:0]             checksum;
    logic                   accept;
    logic                   last_word;

    assign accept    = byte_valid && byte_ready;
    assign rx_count  = {word_count[HDR_WIDTH-1:8], byte_data};
    assign last_word = (word_index + 16'd1) == word_count;

    // State register; reset returns to IDLE from anywhere, aborting a load.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and per-state output levels.
    always_comb begin
        next_state = state;
        byte_ready = 1'b0;
        wr_en      = 1'b0;
        cpu_reset  = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (state == DONE) begin
                    cpu_reset = 1'b0;
                    done      = 1'b1;
                end
                if (state == ERR) begin
                    error = 1'b1;
                end
                if (start) begin
                    next_state = LEN_HI;
                end
            end
            LEN_HI: begin
                byte_ready = 1'b1;
                if (accept) begin
                    next_state = LEN_LO;
                end
            end
            LEN_LO: begin
                byte_ready = 1'b1;
                if (accept) begin
                    if (32'(rx_count) > MAX_LIMIT) begin
                        next_state = ERR;
                    end else if (rx_count == '0) begin
                        next_state = CHECK;
                    end else begin
                        next_state = DATA;
                    end
                end
            end
            DATA: begin
                byte_ready = 1'b1;
                if (accept && byte_pos == 2'd3) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                wr_en      = 1'b1;
                next_state = last_word ? CHECK : DATA;
            end
            CHECK: begin
                byte_ready = 1'b1;
                if (accept) begin
                    next_state = (byte_data == checksum) ? DONE : ERR;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: header capture, word assembly, checksum and write address.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_count <= '0;
            word_index <= '0;
            byte_pos   <= 2'd0;
            assembly   <= 24'd0;
            checksum   <= 8'd0;
            wr_addr    <= BASE_ADDR;
            wr_data    <= 32'd0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        checksum   <= 8'd0;
                        word_index <= '0;
                        byte_pos   <= 2'd0;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        word_count[HDR_WIDTH-1:8] <= byte_data;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        word_count[7:0] <= byte_data;
                    end
                end
                DATA: begin
                    if (accept) begin
                        checksum <= checksum ^ byte_data;
                        byte_pos <= byte_pos + 2'd1;
                        if (byte_pos == 2'd3) begin
                            wr_data <= {assembly, byte_data};
                            wr_addr <= BASE_ADDR + (32'(word_index) << 2);
                        end else begin
                            assembly <= {assembly[15:0], byte_data};
                        end
                    end
                end
                WRITE: begin
                    word_index <= word_index + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a table of whole images plus hand-written
// sequences for reset mid-load and a stray start pulse during DATA.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int tests = 0;
    int fails = 0;
    bit toggle_mode = 1'b0;

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];

    typedef struct {
        string        name;
        logic [15:0]  n;
        logic [95:0]  words;
        logic [7:0]   csum;
        bit           toggle;
        bit           len_err;
        int           exp_writes;
        bit           exp_done;
        bit           exp_err;
    } vec_t;

    vec_t vecs[8];

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Record every write strobe; a write must never coincide with byte_ready.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
            check_output("write_without_ready", {31'd0, byte_ready}, 32'd0);
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        byte_valid = 1'b0;
        byte_data  = 8'hFF;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer one byte and return right after the edge that accepts it.
    task automatic apply_stimulus(input logic [7:0] b);
        int waited;
        if (toggle_mode) begin
            @(negedge clk);
            byte_valid = 1'b0;
            byte_data  = 8'hFF;
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        waited = 0;
        while (byte_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            check_output("ready_timeout", {31'd0, byte_ready}, 32'd1);
            byte_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
        check_output({tag, "_wr_en"},      {31'd0, wr_en},      32'd0);
        check_output({tag, "_wr_addr"},    wr_addr,             32'd0);
        check_output({tag, "_wr_data"},    wr_data,             32'd0);
        check_output({tag, "_cpu_reset"},  {31'd0, cpu_reset},  32'd1);
        check_output({tag, "_done"},       {31'd0, done},       32'd0);
        check_output({tag, "_error"},      {31'd0, error},      32'd0);
    endtask

    task automatic run_image(input vec_t v);
        logic [31:0] w;
        got_addr.delete();
        got_data.delete();
        toggle_mode = v.toggle;
        pulse_start();
        apply_stimulus(v.n[15:8]);
        apply_stimulus(v.n[7:0]);
        if (v.len_err) begin
            #1;
            check_output({v.name, "_len_error"}, {31'd0, error}, 32'd1);
        end else begin
            for (int i = 0; i < int'(v.n); i++) begin
                w = v.words[95 - 32*i -: 32];
                for (int b = 0; b < 4; b++) begin
                    apply_stimulus(w[31 - 8*b -: 8]);
                end
                #1;
                check_output({v.name, "_wr_latency"}, {31'd0, wr_en}, 32'd1);
            end
            apply_stimulus(v.csum);
            #1;
            check_output({v.name, "_done_latency"},  {31'd0, done},  {31'd0, v.exp_done});
            check_output({v.name, "_error_latency"}, {31'd0, error}, {31'd0, v.exp_err});
        end
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_output({v.name, "_write_count"}, 32'(got_addr.size()), 32'(v.exp_writes));
        for (int i = 0; i < v.exp_writes && i < got_addr.size(); i++) begin
            check_output({v.name, "_addr"}, got_addr[i], 32'(4*i));
            check_output({v.name, "_data"}, got_data[i], v.words[95 - 32*i -: 32]);
        end
        check_output({v.name, "_done"},      {31'd0, done},      {31'd0, v.exp_done});
        check_output({v.name, "_error"},     {31'd0, error},     {31'd0, v.exp_err});
        check_output({v.name, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, ~v.exp_done});
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vecs[0] = '{"two_words",      16'd2,      {32'h2008_0005, 32'h0000_0000, 32'h0}, 8'h2D, 1'b0, 1'b0, 2, 1'b1, 1'b0};
        vecs[1] = '{"two_words_gap",  16'd2,      {32'h2008_0005, 32'h0000_0000, 32'h0}, 8'h2D, 1'b1, 1'b0, 2, 1'b1, 1'b0};
        vecs[2] = '{"bad_csum",       16'd1,      {32'h1234_5678, 32'h0, 32'h0},         8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b1};
        vecs[3] = '{"len_257",        16'h0101,   96'h0,                                 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1};
        vecs[4] = '{"zero_words",     16'd0,      96'h0,                                 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0};
        vecs[5] = '{"three_words",    16'd3,      {32'hDEAD_BEEF, 32'h0102_0304, 32'hA5A5_A5A5}, 8'h26, 1'b1, 1'b0, 3, 1'b1, 1'b0};
        vecs[6] = '{"len_ffff",       16'hFFFF,   96'h0,                                 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1};
        vecs[7] = '{"zero_bad_csum",  16'd0,      96'h0,                                 8'h01, 1'b0, 1'b0, 0, 1'b0, 1'b1};

        reset      = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_idle("reset_held");
        reset = 1'b0;
        @(negedge clk);
        check_idle("after_reset");

        for (int i = 0; i < 8; i++) begin
            run_image(vecs[i]);
        end

        // Reset after six payload bytes of a three-word load: one write, then IDLE.
        got_addr.delete();
        got_data.delete();
        toggle_mode = 1'b0;
        pulse_start();
        apply_stimulus(8'h00);
        apply_stimulus(8'h03);
        apply_stimulus(8'hDE);
        apply_stimulus(8'hAD);
        apply_stimulus(8'hBE);
        apply_stimulus(8'hEF);
        apply_stimulus(8'h01);
        apply_stimulus(8'h02);
        @(negedge clk);
        byte_valid = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle("mid_reset");
        repeat (5) @(negedge clk);
        check_output("mid_reset_writes", 32'(got_addr.size()), 32'd1);
        check_output("mid_reset_ready",  {31'd0, byte_ready}, 32'd0);
        run_image(vecs[0]);

        // A start pulse in the middle of DATA must not restart the load.
        got_addr.delete();
        got_data.delete();
        pulse_start();
        apply_stimulus(8'h00);
        apply_stimulus(8'h01);
        apply_stimulus(8'h12);
        apply_stimulus(8'h34);
        pulse_start();
        apply_stimulus(8'h56);
        apply_stimulus(8'h78);
        #1;
        check_output("start_ignored_wr_en", {31'd0, wr_en}, 32'd1);
        apply_stimulus(8'h08);
        @(negedge clk);
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_output("start_ignored_writes", 32'(got_addr.size()), 32'd1);
        if (got_addr.size() > 0) begin
            check_output("start_ignored_addr", got_addr[0], 32'h0000_0000);
            check_output("start_ignored_data", got_data[0], 32'h1234_5678);
        end
        check_output("start_ignored_done",      {31'd0, done},      32'd1);
        check_output("start_ignored_cpu_reset", {31'd0, cpu_reset}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
